// File: rtl/ppm_pkg.sv
// Shared types and constants for the 4-PPM receive path.
package ppm_pkg;

  typedef logic [1:0] ppm_state_t;

  localparam ppm_state_t IDLE  = 2'd0;
  localparam ppm_state_t START = 2'd1;
  localparam ppm_state_t DATA  = 2'd2;

  localparam int ERR_BIT   = 2;
  localparam int PPM_SLOTS = 4;

  function automatic logic [1:0] lowest_hit(input logic [PPM_SLOTS-1:0] v);
    lowest_hit = 2'd0;
    for (int i = PPM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_hit = 2'(i);
    end
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic multi_hit(input logic [PPM_SLOTS-1:0] v);
    multi_hit = ((v & (v - PPM_SLOTS'(1))) != '0);
  endfunction

endpackage

// File: rtl/ppm_sync_edge.sv
// Synchronizes ppm_in, detects rising edges and gates them with the armed flag.
// s lags ppm_in by SYNC_STAGES clk16; no backpressure.
module ppm_sync_edge
  import ppm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk16,
  input  logic rst,
  input  logic ppm_in,
  input  logic idle,
  input  logic disarm,
  output logic s,
  output logic start_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   s_prev;
  logic                   armed;

  // fill_q marks when the reset zeros have flushed out of sync_q, so a line held
  // high through reset release never looks like a low sample that could arm us.
  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      s_prev <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ppm_in};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      s_prev <= s;
      if (disarm) begin
        armed <= 1'b0;
      end else if (idle && fill_q[SYNC_STAGES] && !s) begin
        armed <= 1'b1;
      end
    end
  end

  assign s          = sync_q[SYNC_STAGES-1];
  assign start_rise = armed && s && !s_prev;

endmodule

// File: rtl/ppm_symbol_demod.sv
// 4-PPM front end: locks on a start pulse and classifies each 4-slot symbol.
// Strobe 1 clk16 after the last sample of slot 3; no backpressure, downstream must accept every strobe.
module ppm_symbol_demod
  import ppm_pkg::*;
#(
  parameter int SLOT_LEN    = 16,
  parameter int START_MIN   = 24,
  parameter int START_MAX   = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk16,
  input  logic       rst,
  input  logic       ppm_in,
  output logic [2:0] data_3bits_out,
  output logic       finish2bits,
  output logic       eof,
  output logic       busy
);

  localparam int SCW = $clog2(SLOT_LEN);
  localparam int HCW = SCW + 1;
  localparam int WCW = $clog2(START_MAX) + 1;

  localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOT_LEN - 1);
  localparam logic [HCW-1:0] HALF      = HCW'(SLOT_LEN / 2);
  localparam logic [WCW-1:0] W_MIN     = WCW'(START_MIN);
  localparam logic [WCW-1:0] W_MAX     = WCW'(START_MAX);

  ppm_state_t           state;
  logic [WCW-1:0]       width_cnt;
  logic [SCW-1:0]       slot_cnt;
  logic [1:0]           slot_idx;
  logic [HCW-1:0]       high_cnt;
  logic [HCW-1:0]       high_next;
  logic [PPM_SLOTS-1:0] hit_q;
  logic [PPM_SLOTS-1:0] hit_next;
  logic                 s;
  logic                 start_rise;
  logic                 idle;
  logic                 disarm;
  logic                 slot_end;
  logic                 sym_end;
  logic                 slot_hit;

  ppm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk16      (clk16),
    .rst        (rst),
    .ppm_in     (ppm_in),
    .idle       (idle),
    .disarm     (disarm),
    .s          (s),
    .start_rise (start_rise)
  );

  assign idle      = (state == IDLE);
  assign busy      = !idle;
  assign slot_end  = (state == DATA) && (slot_cnt == SLOT_LAST);
  assign sym_end   = slot_end && (slot_idx == 2'(PPM_SLOTS - 1));
  assign high_next = high_cnt + HCW'(s);
  assign slot_hit  = (high_next >= HALF);

  // The decision uses the hit vector including the slot finishing this cycle.
  always_comb begin
    hit_next           = hit_q;
    hit_next[slot_idx] = slot_hit;
  end

  assign disarm = ((state == START) && s && (width_cnt >= W_MAX)) ||
                  (sym_end && (hit_next == '0));

  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      width_cnt      <= '0;
      slot_cnt       <= '0;
      slot_idx       <= '0;
      high_cnt       <= '0;
      hit_q          <= '0;
      data_3bits_out <= 3'b000;
      finish2bits    <= 1'b0;
      eof            <= 1'b0;
    end else begin
      finish2bits <= 1'b0;
      eof         <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state     <= START;
            width_cnt <= WCW'(1);
          end
        end
        START: begin
          if (s) begin
            if (width_cnt >= W_MAX) state <= IDLE;
            else                    width_cnt <= width_cnt + WCW'(1);
          end else if (width_cnt >= W_MIN) begin
            state    <= DATA;
            slot_cnt <= '0;
            slot_idx <= '0;
            high_cnt <= '0;
            hit_q    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          slot_cnt <= slot_cnt + SCW'(1);
          if (slot_end) begin
            high_cnt <= '0;
            hit_q    <= hit_next;
            slot_idx <= slot_idx + 2'd1;
          end else begin
            high_cnt <= high_next;
          end
          if (sym_end) begin
            if (hit_next == '0) begin
              eof   <= 1'b1;
              state <= IDLE;
            end else begin
              finish2bits             <= 1'b1;
              data_3bits_out[ERR_BIT] <= multi_hit(hit_next);
              data_3bits_out[1:0]     <= lowest_hit(hit_next);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_symbol_demod.sv
// Directed bench for ppm_symbol_demod: stimulus pushes expected strobes, a monitor pops and compares.
module tb_ppm_symbol_demod;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 65;

  logic       clk16 = 1'b0;
  logic       rst;
  logic       ppm_in;
  logic [2:0] data_3bits_out;
  logic       finish2bits;
  logic       eof;
  logic       busy;

  ppm_symbol_demod #(
    .SLOT_LEN    (16),
    .START_MIN   (24),
    .START_MAX   (40),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk16          (clk16),
    .rst            (rst),
    .ppm_in         (ppm_in),
    .data_3bits_out (data_3bits_out),
    .finish2bits    (finish2bits),
    .eof            (eof),
    .busy           (busy)
  );

  always #5 clk16 = ~clk16;

  int cyc = 0;
  always @(posedge clk16) cyc <= cyc + 1;

  typedef struct {
    logic       is_eof;
    logic [2:0] dat;
    int         at;
    logic       chk_byte;
    logic [7:0] byte_exp;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         next_at = 0;
  int         n_pass = 0;
  int         n_tot = 0;
  logic [7:0] asm_byte = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk16) begin
    if (rst) begin
      asm_byte = 8'h00;
    end else if (finish2bits || eof) begin
      check("strobe_exclusive", int'(finish2bits & eof), 0);
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_event: finish2bits=%0b eof=%0b data=%0d at cycle %0d, none expected",
                 finish2bits, eof, data_3bits_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind_eof", int'(eof), int'(mon_e.is_eof));
        check("event_cycle", cyc, mon_e.at);
        if (mon_e.is_eof) begin
          check("busy_at_eof", int'(busy), 0);
          if (mon_e.chk_byte) check("assembled_byte", int'(asm_byte), int'(mon_e.byte_exp));
        end else begin
          check("symbol_data", int'(data_3bits_out), int'(mon_e.dat));
        end
      end
      if (finish2bits) asm_byte = {data_3bits_out[1:0], asm_byte[7:2]};
      if (eof)         asm_byte = 8'h00;
    end
  end

  task automatic drv(input logic v, input int n);
    repeat (n) begin
      @(posedge clk16);
      #1 ppm_in = v;
    end
  endtask

  // Start pulse, then one low cycle that ends it; slot 0 of symbol 0 follows.
  task automatic start_frame(input int w);
    drv(1'b1, w);
    drv(1'b0, 1);
    next_at = cyc + LAT;
  endtask

  // One symbol: c0..c3 = high samples at the start of each 16-cycle slot.
  task automatic send_sym(input int c0, input int c1, input int c2, input int c3,
                          input logic is_eof, input logic [2:0] dat,
                          input logic chk, input logic [7:0] bexp);
    exp_t e;
    e.is_eof   = is_eof;
    e.dat      = dat;
    e.at       = next_at;
    e.chk_byte = chk;
    e.byte_exp = bexp;
    sb.push_back(e);
    next_at += 64;
    drv(1'b1, c0); drv(1'b0, 16 - c0);
    drv(1'b1, c1); drv(1'b0, 16 - c1);
    drv(1'b1, c2); drv(1'b0, 16 - c2);
    drv(1'b1, c3); drv(1'b0, 16 - c3);
  endtask

  task automatic sym(input int c0, input int c1, input int c2, input int c3, input logic [2:0] dat);
    send_sym(c0, c1, c2, c3, 1'b0, dat, 1'b0, 8'h00);
  endtask

  task automatic end_frame(input logic chk, input logic [7:0] bexp);
    send_sym(0, 0, 0, 0, 1'b1, 3'b000, chk, bexp);
    drv(1'b0, 10);
  endtask

  task automatic pulse_rst();
    @(posedge clk16);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk16);
    #1;
    check("rst_data", int'(data_3bits_out), 0);
    check("rst_finish", int'(finish2bits), 0);
    check("rst_eof", int'(eof), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    ppm_in = 1'b0;
    repeat (3) @(posedge clk16);
    #1;
    check("por_data", int'(data_3bits_out), 0);
    check("por_finish", int'(finish2bits), 0);
    check("por_eof", int'(eof), 0);
    check("por_busy", int'(busy), 0);
    rst = 1'b0;
    drv(1'b0, 8);

    // Clean symbol in slot 2
    start_frame(32);
    sym(0, 0, 16, 0, 3'b010);
    end_frame(1'b0, 8'h00);

    // Full byte: slots 3,0,1,2 then an empty symbol
    start_frame(32);
    sym(0, 0, 0, 16, 3'b011);
    sym(16, 0, 0, 0, 3'b000);
    sym(0, 16, 0, 0, 3'b001);
    sym(0, 0, 16, 0, 3'b010);
    end_frame(1'b1, 8'b10_01_00_11);
    check("data_hold_after_eof", int'(data_3bits_out), 3'b010);

    // Start rejection: short glitch, then over-long pulse
    drv(1'b1, 20);
    check("busy_during_glitch", int'(busy), 1);
    drv(1'b0, 10);
    check("busy_after_glitch", int'(busy), 0);
    drv(1'b1, 30);
    check("busy_long_pulse_mid", int'(busy), 1);
    drv(1'b1, 18);
    check("busy_long_pulse_abort", int'(busy), 0);
    drv(1'b1, 20);
    check("busy_line_still_high", int'(busy), 0);
    drv(1'b0, 10);
    start_frame(32);
    sym(0, 16, 0, 0, 3'b001);
    end_frame(1'b0, 8'h00);

    // Malformed symbol then a valid one
    start_frame(32);
    sym(0, 16, 0, 16, 3'b101);
    sym(16, 0, 0, 0, 3'b000);
    end_frame(1'b0, 8'h00);

    // Majority boundary: 8 samples is a hit, 7 is an empty symbol
    start_frame(24);
    sym(0, 8, 0, 0, 3'b001);
    end_frame(1'b0, 8'h00);
    start_frame(40);
    send_sym(0, 7, 0, 0, 1'b1, 3'b000, 1'b0, 8'h00);
    drv(1'b0, 10);

    // Line held high across reset release must not start a frame
    drv(1'b1, 1);
    pulse_rst();
    drv(1'b1, 10);
    check("busy_high_after_rst", int'(busy), 0);
    drv(1'b1, 50);
    check("busy_high_long_after_rst", int'(busy), 0);
    drv(1'b0, 10);
    start_frame(32);
    sym(0, 0, 16, 0, 3'b010);
    end_frame(1'b0, 8'h00);

    // Reset in the middle of a symbol discards it
    start_frame(32);
    drv(1'b1, 16);
    drv(1'b0, 14);
    pulse_rst();
    ppm_in = 1'b0;
    drv(1'b0, 10);
    check("busy_after_mid_rst", int'(busy), 0);
    check("data_after_mid_rst", int'(data_3bits_out), 0);
    start_frame(32);
    sym(0, 0, 0, 16, 3'b011);
    end_frame(1'b0, 8'h00);

    drv(1'b0, 20);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
